clic_gateway_adapter: RTL
=========================

# clic_gateway_adapter

Per-source interrupt gateway sitting between the raw interrupt lines and the CLIC register file / arbiter. It generalises the register-field adapter stage with all four CLIC trigger modes (positive/negative, level/edge), a configurable input synchroniser, and a registered pending bit. Edge-pending state is cleared by core acknowledge or by software write, and level-pending tracks the line. Outputs feed the `ip` hardware-write port of the `clicint` registers and the priority arbiter.

## Interface
- `N_SOURCE`, 32: number of interrupt sources (≥1).
- `SYNC_STAGES`, 2: synchroniser depth on `src_i`; 0 = bypass (source already in `clk_i` domain).
- `IdWidth`, `$clog2(N_SOURCE)` (min 1): width of acknowledge id.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `src_i` in N_SOURCE: raw interrupt lines.
- `trig_i` in [N_SOURCE][1:0]: `attr_trig`; bit0 = 1 edge / 0 level; bit1 = 1 negative (falling/low) / 0 positive.
- `ie_i` in N_SOURCE: interrupt enable.
- `sw_ip_we_i` in N_SOURCE: one-cycle software write strobe to `ip`.
- `sw_ip_d_i` in N_SOURCE: software write data.
- `ack_valid_i` in 1: core claims an interrupt this cycle.
- `ack_id_i` in IdWidth: claimed source index.
- `ip_o` out N_SOURCE: registered pending; drives `clicint.ip.d`.
- `ip_de_o` out N_SOURCE: constant 1 (register mirrors `ip_o` every cycle).
- `pend_o` out N_SOURCE: `ip_o & ie_i` (combinational), to arbiter.
- `any_pend_o` out 1: OR of `pend_o`.

## Operation
- Synchroniser: `SYNC_STAGES` flops per source → `sync`. Then `prev` = `sync` delayed one cycle (raw, unnormalised).
- Normalise: `act = sync ^ trig[1]`; `prev_act = prev ^ trig[1]` (uses current `trig`). Edge = `act & ~prev_act`. Changing `trig` with a constant line never creates an edge.
- Level mode (`trig[0]=0`): `ip_q <= act` every cycle. Software writes and acks are ignored.
- Edge mode (`trig[0]=1`), next-state priority, highest first:
  1. Edge → 1.
  2. `sw_ip_we_i` → `sw_ip_d_i`.
  3. `ack_valid_i && ack_id_i==i` → 0.
  4. Otherwise hold.
- Simultaneous edge + ack on the same source: stays 1 (edge not lost). Simultaneous software write + ack: software value wins.
- `ack_id_i ≥ N_SOURCE`: no effect.
- Mode switch level→edge: `ip_q` keeps its value. Edge→level: `ip_q` follows `act` from the next edge.
- `ie_i` masks only `pend_o`. Pending latches while disabled.

## Timing
- Reset (`rst_ni` low at a rising edge): all sync, `prev` and `ip_q` flops = 0. Next cycle: `ip_o=0`, `pend_o=0`, `any_pend_o=0`. In-flight edges and pending state are discarded.
- Negative-polarity source held low through reset: no spurious edge after reset. Level-low source asserts `ip_o` `SYNC_STAGES+1` cycles after reset release.
- Latency, `src_i` change → `ip_o`: `SYNC_STAGES+1` rising edges (1 when bypassed). `pend_o`/`any_pend_o` follow in the same cycle.
- Software write / ack → `ip_o` updated after 1 edge.
- Minimum detectable edge-mode pulse: 1 `clk_i` cycle (after sync). Two edges before an ack collapse into one pending.

## Structure
- `clic_gw_pkg`: trigger encodings `TRIG_POS_LEVEL=2'b00`, `TRIG_POS_EDGE=2'b01`, `TRIG_NEG_LEVEL=2'b10`, `TRIG_NEG_EDGE=2'b11`, `trig_e` typedef.
- Sub-module `clic_gw_cell` (one source: synchroniser, edge detect, pending FSM), instantiated N_SOURCE times via generate. Ack decode and `any_pend_o` reduction live in the top.

## Test plan
- Positive edge, `SYNC_STAGES=2`: `src_i[3]` 0→1 at cycle 10 → `ip_o[3]=1` at cycle 13; ack id 3 at cycle 20 → `ip_o[3]=0` at 21 although `src_i[3]` still high.
- Negative level on source 0 held low through reset → `ip_o[0]=0` during reset, 1 at the 3rd edge after release. Raise the line → cleared 3 cycles later. Software write 0 is ignored.
- Edge + ack same cycle on source 5 → `ip_o[5]` stays 1. Software write 1 + ack same cycle → 1. Software write 0 with no edge → 0.
- `ie_i[7]=0` with pending 7 → `pend_o[7]=0`, `any_pend_o=0`. Set `ie_i[7]=1` → both 1 in the same cycle.
- Flip `trig_i[2][1]` with `src_i[2]` constant in edge mode → no pending. `ack_id_i=N_SOURCE` (when not a power of two) → no state change.
- Synchronous reset asserted while 4 sources pending → all outputs 0 the cycle after. No edges detected on release for steady lines.

Source files
------------

// File: rtl/clic_gateway_adapter_pkg.sv
// rtl/clic_gateway_adapter_pkg.sv - CLIC gateway trigger encodings, pending state and decode helpers
package clic_gw_pkg;

   // attr_trig encoding: bit0 selects edge (1) or level (0), bit1 selects negative polarity
   typedef enum logic [1:0] {
      TRIG_POS_LEVEL = 2'b00,
      TRIG_POS_EDGE  = 2'b01,
      TRIG_NEG_LEVEL = 2'b10,
      TRIG_NEG_EDGE  = 2'b11
   } trig_e;

   // Per-source pending state
   typedef enum logic {
      PEND_IDLE = 1'b0,
      PEND_SET  = 1'b1
   } pend_e;

   function automatic logic trig_is_edge(input logic [1:0] trig);
      return trig[0];
   endfunction

   function automatic logic trig_is_neg(input logic [1:0] trig);
      return trig[1];
   endfunction

endpackage

// File: rtl/clic_gateway_adapter_cell.sv
// rtl/clic_gateway_adapter_cell.sv - one interrupt source: synchroniser, edge detect, pending state
module clic_gw_cell
   import clic_gw_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       src,
   input  logic [1:0] trig,
   input  logic       sw_we,
   input  logic       sw_d,
   input  logic       ack,
   output logic       ip
);

   logic                 sync;
   logic                 sync_valid;
   logic                 prev;
   logic                 prev_valid;
   logic [SYNC_STAGES:0] fill_q;
   logic                 neg;
   logic                 edge_mode;
   logic                 act;
   logic                 prev_act;
   logic                 edge_hit;
   pend_e                state_q;
   pend_e                state_d;

   // Marks how far real line samples have travelled since reset; the reset
   // contents of the synchroniser and prev flops are never treated as samples,
   // so steady lines cannot fake an edge on release
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_q <= '0;
      end else begin
         fill_q <= (fill_q << 1) | (SYNC_STAGES + 1)'(1);
      end
   end

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign sync       = src;
         assign sync_valid = 1'b1;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         // Synchroniser chain into the clk domain
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= src;
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end

         assign sync       = sync_q[SYNC_STAGES-1];
         assign sync_valid = fill_q[SYNC_STAGES-1];
      end
   endgenerate

   assign prev_valid = fill_q[SYNC_STAGES];

   // Previous synchronised sample, kept raw so a polarity change alone is not an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev <= 1'b0;
      end else begin
         prev <= sync;
      end
   end

   assign neg       = trig_is_neg(trig);
   assign edge_mode = trig_is_edge(trig);
   assign act       = sync ^ neg;
   assign prev_act  = prev ^ neg;
   assign edge_hit  = prev_valid & act & ~prev_act;

   // Pending state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PEND_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Level mode tracks the line; edge mode: edge beats software write beats ack
   always_comb begin
      state_d = state_q;
      if (!edge_mode) begin
         state_d = (sync_valid & act) ? PEND_SET : PEND_IDLE;
      end else if (edge_hit) begin
         state_d = PEND_SET;
      end else if (sw_we) begin
         state_d = sw_d ? PEND_SET : PEND_IDLE;
      end else if (ack) begin
         state_d = PEND_IDLE;
      end
   end

   assign ip = (state_q == PEND_SET);

endmodule

// File: rtl/clic_gateway_adapter.sv
// rtl/clic_gateway_adapter.sv - per-source CLIC interrupt gateway feeding clicint.ip and the arbiter
module clic_gateway_adapter
   import clic_gw_pkg::*;
#(
   parameter int N_SOURCE    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int IdWidth     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_SOURCE-1:0]      src_i,
   input  logic [N_SOURCE-1:0][1:0] trig_i,
   input  logic [N_SOURCE-1:0]      ie_i,
   input  logic [N_SOURCE-1:0]      sw_ip_we_i,
   input  logic [N_SOURCE-1:0]      sw_ip_d_i,
   input  logic                     ack_valid_i,
   input  logic [IdWidth-1:0]       ack_id_i,
   output logic [N_SOURCE-1:0]      ip_o,
   output logic [N_SOURCE-1:0]      ip_de_o,
   output logic [N_SOURCE-1:0]      pend_o,
   output logic                     any_pend_o
);

   logic [N_SOURCE-1:0] ack_vec;

   // One-hot acknowledge decode; ids beyond the last source match nothing
   always_comb begin
      ack_vec = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         ack_vec[i] = ack_valid_i && (ack_id_i == IdWidth'(i));
      end
   end

   generate
      for (genvar i = 0; i < N_SOURCE; i++) begin : g_cell
         clic_gw_cell #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_cell (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .src   (src_i[i]),
            .trig  (trig_i[i]),
            .sw_we (sw_ip_we_i[i]),
            .sw_d  (sw_ip_d_i[i]),
            .ack   (ack_vec[i]),
            .ip    (ip_o[i])
         );
      end
   endgenerate

   assign ip_de_o    = '1;
   assign pend_o     = ip_o & ie_i;
   assign any_pend_o = |pend_o;

endmodule
